// File: rtl/seg7_readback.sv
// ---------------------------------------------------------------------------
// seg7_readback
//
// Watches a seven-segment bus and reconstructs the digit being displayed.
// The raw segments and the polarity select are synchronised, normalised to
// "1 = lit", and a pattern is accepted once it has been steady for
// STABLE_CYCLES consecutive samples. Each accepted change is decoded and
// offered on a one-entry valid/ready buffer.
//
// Optional feature: define SEG7_READBACK_HEX_EN to also decode the hex
// letters A..F (0x7C then reads as B instead of 6).
//
// Parameters:
//   STABLE_CYCLES  identical normalised samples needed to accept (2..255)
//   CHG_W          width of the accepted-change counter
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   seg_in[6:0]     raw segments {g,f,e,d,c,b,a}
//   common_cathode  1: lit when high, 0: lit when low (common anode)
//   out_digit[3:0]  decoded value of the accepted pattern
//   out_blank       accepted pattern has every segment off
//   out_invalid     accepted pattern has no legal decoding
//   out_valid       buffered result available
//   out_ready       consumer takes the buffered result
//   overrun         sticky: a result was overwritten before being taken
//   change_count    number of accepted pattern changes (wraps)
// ---------------------------------------------------------------------------
module seg7_readback #(
    parameter int STABLE_CYCLES = 16,
    parameter int CHG_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             common_cathode,
    output logic [3:0]       out_digit,
    output logic             out_blank,
    output logic             out_invalid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CHG_W-1:0] change_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Returns {invalid, blank, digit[3:0]}.
    function automatic logic [5:0] decode_pat(input logic [6:0] pat);
        logic [5:0] res;
        res = 6'b10_0000;
        case (pat)
            7'h00:   res = 6'b01_0000;
            7'h3F:   res = {2'b00, 4'h0};
            7'h06:   res = {2'b00, 4'h1};
            7'h5B:   res = {2'b00, 4'h2};
            7'h4F:   res = {2'b00, 4'h3};
            7'h66:   res = {2'b00, 4'h4};
            7'h6D:   res = {2'b00, 4'h5};
            7'h7D:   res = {2'b00, 4'h6};
            7'h07:   res = {2'b00, 4'h7};
            7'h7F:   res = {2'b00, 4'h8};
            7'h6F:   res = {2'b00, 4'h9};
            7'h67:   res = {2'b00, 4'h9};
`ifdef SEG7_READBACK_HEX_EN
            7'h77:   res = {2'b00, 4'hA};
            7'h7C:   res = {2'b00, 4'hB};
            7'h39:   res = {2'b00, 4'hC};
            7'h5E:   res = {2'b00, 4'hD};
            7'h79:   res = {2'b00, 4'hE};
            7'h71:   res = {2'b00, 4'hF};
`else
            // Six without the top bar.
            7'h7C:   res = {2'b00, 4'h6};
`endif
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    // Input path
    logic [6:0] seg_s1_q, seg_s2_q;
    logic       cc_s1_q, cc_s2_q;
    logic [6:0] norm;
    logic [6:0] prev_q;
    logic [7:0] cnt_q, cnt_d;
    logic       stable_now;

    assign norm       = cc_s2_q ? seg_s2_q : ~seg_s2_q;
    assign stable_now = (norm == prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!stable_now) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // The polarity flops reset to "cathode" so the normalised pattern reads
    // blank straight after reset, agreeing with the reset value of prev_q
    // and of the last-accepted pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            cc_s1_q  <= 1'b1;
            cc_s2_q  <= 1'b1;
            prev_q   <= '0;
            cnt_q    <= '0;
        end else begin
            seg_s1_q <= seg_in;
            seg_s2_q <= seg_s1_q;
            cc_s1_q  <= common_cathode;
            cc_s2_q  <= cc_s1_q;
            prev_q   <= norm;
            cnt_q    <= cnt_d;
        end
    end

    // Acceptance FSM and result buffer
    state_t           state_q;
    logic [6:0]       last_q;
    logic [3:0]       digit_q;
    logic             blank_q, invalid_q, valid_q, overrun_q;
    logic [CHG_W-1:0] change_q;
    logic             lock_now, new_event;
    logic [5:0]       dec;

    // Lock needs the count saturated and this cycle's sample to agree too,
    // so a change arriving on the would-be lock cycle restarts settling.
    assign lock_now  = (state_q == SETTLING) && stable_now && (cnt_q == CNT_MAX);
    // Settling back onto the pattern already reported is not a new event.
    assign new_event = lock_now && (norm != last_q);
    assign dec       = decode_pat(norm);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= '0;
            digit_q   <= '0;
            blank_q   <= 1'b0;
            invalid_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            change_q  <= '0;
        end else begin
            case (state_q)
                IDLE:     state_q <= SETTLING;
                SETTLING: if (lock_now) state_q <= LOCKED;
                LOCKED:   if (!stable_now) state_q <= SETTLING;
                default:  state_q <= IDLE;
            endcase

            // A new event always wins the buffer; it only counts as an
            // overrun if the previous result was still unclaimed.
            if (new_event) begin
                digit_q   <= dec[3:0];
                blank_q   <= dec[4];
                invalid_q <= dec[5];
                valid_q   <= 1'b1;
                last_q    <= norm;
                change_q  <= change_q + CHG_W'(1);
                if (valid_q && !out_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_digit    = digit_q;
    assign out_blank    = blank_q;
    assign out_invalid  = invalid_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;
    assign change_count = change_q;

endmodule

// File: tb/tb_seg7_readback.sv
module tb_seg7_readback;

    localparam int S = 16;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic       common_cathode;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_invalid;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic [7:0] change_count;

    int errors = 0;
    int checks = 0;

    seg7_readback #(.STABLE_CYCLES(S), .CHG_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .seg_in         (seg_in),
        .common_cathode (common_cathode),
        .out_digit      (out_digit),
        .out_blank      (out_blank),
        .out_invalid    (out_invalid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overrun        (overrun),
        .change_count   (change_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Works on the stream of normalised input samples: a value held for
    // S+1 consecutive samples that differs from the last reported value
    // becomes a result two edges later (synchroniser delay).
    logic       m_valid, m_blank, m_inv, m_over;
    logic [3:0] m_digit;
    logic [7:0] m_cnt;
    logic [6:0] m_last;
    logic [6:0] run_val;
    int         run_len;
    logic       pipe_v [2];
    logic [6:0] pipe_p [2];

    // Returns {invalid, blank, digit}.
    function automatic logic [5:0] model_decode(input logic [6:0] p);
        logic [6:0] digits [10];
`ifdef SEG7_READBACK_HEX_EN
        logic [6:0] hexl [6];
        hexl = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 6; i++) if (p == hexl[i]) return {2'b00, 4'(i + 10)};
`endif
        digits = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (p == 7'h00) return 6'b01_0000;
        for (int i = 0; i < 10; i++) if (p == digits[i]) return {2'b00, 4'(i)};
        if (p == 7'h67) return {2'b00, 4'd9};
        if (p == 7'h7C) return {2'b00, 4'd6};
        return 6'b10_0000;
    endfunction

    task automatic model_edge();
        logic       fire_v;
        logic [6:0] fire_p;
        logic [6:0] r;
        logic [5:0] d;
        if (rst) begin
            m_valid = 0; m_blank = 0; m_inv = 0; m_over = 0;
            m_digit = 0; m_cnt = 0; m_last = 0;
            run_val = 0; run_len = 0;
            pipe_v[0] = 0; pipe_v[1] = 0;
            pipe_p[0] = 0; pipe_p[1] = 0;
        end else begin
            fire_v = pipe_v[1];
            fire_p = pipe_p[1];
            pipe_v[1] = pipe_v[0];
            pipe_p[1] = pipe_p[0];
            pipe_v[0] = 0;
            if (fire_v) begin
                d = model_decode(fire_p);
                m_digit = d[3:0];
                m_blank = d[4];
                m_inv   = d[5];
                if (m_valid && !out_ready) m_over = 1;
                m_valid = 1;
                m_cnt   = m_cnt + 8'd1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            r = common_cathode ? seg_in : ~seg_in;
            if (r == run_val) run_len++;
            else begin
                run_val = r;
                run_len = 1;
            end
            if (run_len == S + 1 && r != m_last) begin
                pipe_v[0] = 1;
                pipe_p[0] = r;
                m_last    = r;
            end
        end
    endtask

    // One clock: drive after the falling edge, model at the rising edge,
    // return at the next falling edge where outputs are sampled.
    task automatic step(input logic r, input logic [6:0] s, input logic cc, input logic rdy);
        rst = r; seg_in = s; common_cathode = cc; out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Hold one input for n cycles, reporting each out_valid cycle.
    task automatic hold(input int n, input logic [6:0] s, input logic cc, input logic rdy,
                        output int pulses, output int first,
                        output logic [3:0] dig, output logic blk, output logic inv);
        pulses = 0; first = -1; dig = 0; blk = 0; inv = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, s, cc, rdy);
            if (out_valid === 1'b1) begin
                if (pulses == 0) begin
                    first = i; dig = out_digit; blk = out_blank; inv = out_invalid;
                end
                pulses++;
                $display("result: seg=%02h cc=%0d digit=%0h blank=%0d invalid=%0d count=%0d",
                         s, cc, out_digit, out_blank, out_invalid, change_count);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) step(1'b1, 7'h00, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
        checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0h want 0", out_digit); end
        checks++; if (out_blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %0d want 0", out_blank); end
        checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid: got %0d want 0", out_invalid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0d want 0", overrun); end
        checks++; if (change_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", change_count); end
    endtask

    task automatic test_latency();
        int p, f; logic [3:0] d; logic b, v;
        hold(30, 7'h5B, 1'b1, 1'b1, p, f, d, b, v);
        checks++; if (p != 1) begin errors++; $display("FAIL lat_pulses: got %0d want 1", p); end
        checks++; if (f != S + 2) begin errors++; $display("FAIL lat_edge: got %0d want %0d", f, S + 2); end
        checks++; if (d !== 4'd2) begin errors++; $display("FAIL lat_digit: got %0h want 2", d); end
        checks++; if (change_count !== 8'd1) begin errors++; $display("FAIL lat_count: got %0d want 1", change_count); end
    endtask

    task automatic test_polarity();
        int p, f; logic [3:0] d; logic b, v;
        hold(25, 7'h19, 1'b0, 1'b1, p, f, d, b, v);
        checks++; if (p != 1) begin errors++; $display("FAIL anode_pulses: got %0d want 1", p); end
        checks++; if (d !== 4'd4) begin errors++; $display("FAIL anode_digit: got %0h want 4", d); end
        checks++; if (change_count !== 8'd2) begin errors++; $display("FAIL anode_count: got %0d want 2", change_count); end
        hold(25, 7'h66, 1'b1, 1'b1, p, f, d, b, v);
        checks++; if (p != 0) begin errors++; $display("FAIL flip_pulses: got %0d want 0", p); end
        checks++; if (change_count !== 8'd2) begin errors++; $display("FAIL flip_count: got %0d want 2", change_count); end
    endtask

    task automatic test_glitch();
        int p1, p2, p3, f; logic [3:0] d, dx; logic b, v;
        hold(25, 7'h6D, 1'b1, 1'b1, p1, f, d, b, v);
        hold(5, 7'h7F, 1'b1, 1'b1, p2, f, dx, b, v);
        hold(25, 7'h6D, 1'b1, 1'b1, p3, f, dx, b, v);
        checks++; if (p1 + p2 + p3 != 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", p1 + p2 + p3); end
        checks++; if (d !== 4'd5) begin errors++; $display("FAIL glitch_digit: got %0h want 5", d); end
        checks++; if (change_count !== 8'd3) begin errors++; $display("FAIL glitch_count: got %0d want 3", change_count); end
    endtask

    task automatic test_overrun();
        int p, f; logic [3:0] d; logic b, v;
        hold(20, 7'h06, 1'b1, 1'b0, p, f, d, b, v);
        hold(20, 7'h4F, 1'b1, 1'b0, p, f, d, b, v);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0d want 1", out_valid); end
        checks++; if (out_digit !== 4'd3) begin errors++; $display("FAIL ovr_digit: got %0h want 3", out_digit); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0d want 1", overrun); end
        checks++; if (change_count !== 8'd5) begin errors++; $display("FAIL ovr_count: got %0d want 5", change_count); end
        step(1'b0, 7'h4F, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %0d want 0", out_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0d want 1", overrun); end
    endtask

    task automatic test_decode();
        logic [6:0] pats [3];
        logic [3:0] wd [3];
        logic       wb [3];
        logic       wi [3];
        int p, f; logic [3:0] d; logic b, v;
        pats = '{7'h00, 7'h49, 7'h7C};
`ifdef SEG7_READBACK_HEX_EN
        wd = '{4'd0, 4'd0, 4'hB};
`else
        wd = '{4'd0, 4'd0, 4'd6};
`endif
        wb = '{1'b1, 1'b0, 1'b0};
        wi = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            hold(22, pats[k], 1'b1, 1'b1, p, f, d, b, v);
            checks++; if (p != 1) begin errors++; $display("FAIL dec_pulses[%02h]: got %0d want 1", pats[k], p); end
            checks++; if (d !== wd[k]) begin errors++; $display("FAIL dec_digit[%02h]: got %0h want %0h", pats[k], d, wd[k]); end
            checks++; if (b !== wb[k]) begin errors++; $display("FAIL dec_blank[%02h]: got %0d want %0d", pats[k], b, wb[k]); end
            checks++; if (v !== wi[k]) begin errors++; $display("FAIL dec_invalid[%02h]: got %0d want %0d", pats[k], v, wi[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int p, f; logic [3:0] d; logic b, v;
        hold(22, 7'h06, 1'b1, 1'b0, p, f, d, b, v);
        hold(5, 7'h3F, 1'b1, 1'b0, p, f, d, b, v);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0d want 1", out_valid); end
        step(1'b1, 7'h3F, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0d want 0", out_valid); end
        checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL mid_digit: got %0h want 0", out_digit); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %0d want 0", overrun); end
        checks++; if (change_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", change_count); end
        hold(22, 7'h06, 1'b1, 1'b0, p, f, d, b, v);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_re_valid: got %0d want 1", out_valid); end
        checks++; if (out_digit !== 4'd1) begin errors++; $display("FAIL mid_re_digit: got %0h want 1", out_digit); end
        checks++; if (change_count !== 8'd1) begin errors++; $display("FAIL mid_re_count: got %0d want 1", change_count); end
    endtask

    task automatic test_random();
        logic [6:0] pool [20];
        logic [6:0] p, raw;
        logic       cc, rdy;
        int         len;
        pool = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h7C, 7'h07, 7'h7F,
                 7'h6F, 7'h67, 7'h00, 7'h49, 7'h77, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h12};
        for (int seg = 0; seg < 70; seg++) begin
            p   = pool[$urandom_range(0, 19)];
            cc  = 1'($urandom_range(0, 1));
            raw = cc ? p : ~p;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                rdy = ($urandom_range(0, 3) != 0);
                step(1'b0, raw, cc, rdy);
                checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %0d want %0d", out_valid, m_valid); end
                if (m_valid) begin
                    checks++;
                    if ({out_invalid, out_blank, out_digit} !== {m_inv, m_blank, m_digit}) begin
                        errors++;
                        $display("FAIL rnd_result: got inv=%0d blank=%0d digit=%0h want inv=%0d blank=%0d digit=%0h",
                                 out_invalid, out_blank, out_digit, m_inv, m_blank, m_digit);
                    end
                end
                checks++; if (overrun !== m_over) begin errors++; $display("FAIL rnd_overrun: got %0d want %0d", overrun, m_over); end
                checks++; if (change_count !== m_cnt) begin errors++; $display("FAIL rnd_count: got %0d want %0d", change_count, m_cnt); end
            end
            $display("rnd segment %0d: pattern=%02h cc=%0d len=%0d count=%0d", seg, p, cc, len, change_count);
        end
    endtask

    initial begin
        rst = 1'b1; seg_in = 7'h00; common_cathode = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_polarity();
        test_glitch();
        test_overrun();
        test_decode();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Receive-side counterpart of the seven-segment encoder path. It watches the segment bus driven on uo_out and reconstructs the displayed digit.
- Synchronises and polarity-normalises the segment pattern, then requires it to be stable for a programmable number of cycles.
- Decodes the stable pattern back to a 4-bit value and presents each new value through a valid/ready handshake with a one-entry buffer.
- Used for on-chip self-check and display readback of dice results.

Parameters:
- STABLE_CYCLES, 16: consecutive identical normalised samples required before a pattern is accepted (range 2..255).
- CHG_W, 8: width of the accepted-change counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- seg_in  in  7  raw segments {g,f,e,d,c,b,a}, bit0 = a.
- common_cathode  in  1  1 = segment lit when its bit is high; 0 = common anode, segment lit when low.
- out_digit  out  4  decoded value of the accepted pattern.
- out_blank  out  1  accepted pattern is all segments off.
- out_invalid  out  1  accepted pattern has no legal decoding.
- out_valid  out  1  buffered result available.
- out_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a result was overwritten before it was consumed.
- change_count  out  CHG_W  number of accepted pattern changes; wraps modulo 2^CHG_W.

Behaviour:
- Reset values: all outputs 0; last-accepted pattern = 0x00 (blank); state IDLE.
- Input path:
  - seg_in and common_cathode pass through a 2-flop synchroniser.
  - Normalised pattern n = common_cathode ? seg : ~seg, computed from the synchronised values.
  - A polarity flip with matching raw inversion leaves n unchanged and generates no event.
- Stability counter:
  - cnt resets to 0 whenever n differs from the previous cycle's n.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- FSM states IDLE, SETTLING, LOCKED:
  - IDLE → SETTLING on the first cycle after reset.
  - SETTLING → LOCKED when cnt reaches STABLE_CYCLES-1.
  - LOCKED → SETTLING on any change of n.
- On entry to LOCKED:
  - If n differs from the last-accepted pattern: load the result register, set out_valid, update the last-accepted pattern, increment change_count.
  - If n equals the last-accepted pattern (glitch and return to the same value): no event, no count.
- Latency: a new pattern held on seg_in from edge k produces out_valid high after edge k+STABLE_CYCLES+2 (two synchroniser edges plus STABLE_CYCLES-1 counting edges plus one register edge).
- Decode table (n → out_digit):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x7C→6, 0x07→7, 0x7F→8, 0x6F→9, 0x67→9.
  - 0x00 → out_digit 0 with out_blank=1.
  - Any other pattern → out_digit 0 with out_invalid=1.
  - out_blank and out_invalid are mutually exclusive and are latched with out_digit.
- Handshake:
  - The transfer completes on a cycle where out_valid && out_ready; out_valid then drops next edge unless a new event loads on the same edge.
  - out_digit, out_blank and out_invalid hold while out_valid=1 and out_ready=0.
- Simultaneous events:
  - New event while out_valid=1 and out_ready=0: the newest result overwrites the old one, out_valid stays 1, overrun is set.
  - New event on the same cycle as a completed transfer: load the new result, out_valid stays 1, no overrun.
- overrun clears only on rst.
- rst mid-operation: returns to reset values on the next edge and discards the pending result and the synchroniser contents.

Optional Feature:
- Macro: SEG7_READBACK_HEX_EN.
- Defined:
  - Additionally decodes 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F.
  - 0x7C decodes as B, not 6.
- Undefined:
  - Those patterns are invalid, except 0x7C, which decodes as 6.

Test Plan:
- Reset, then common_cathode=1, seg_in=0x5B held 30 cycles, out_ready=1 → out_valid pulses once after edge STABLE_CYCLES+2 with out_digit=2, change_count=1.
- common_cathode=0, seg_in=~0x66 (0x19) → out_digit=4. Then flip common_cathode to 1 with seg_in=0x66 on the same cycle → no new event, change_count unchanged.
- seg_in=0x6D, toggle to 0x7F for 5 cycles, back to 0x6D, STABLE_CYCLES=16 → exactly one event (digit 5); no event for 8.
- out_ready=0, present 0x06 then 0x4F, each stable 20 cycles → out_valid stays high, out_digit=3, overrun=1. Raise out_ready → out_valid drops next edge, overrun stays 1.
- seg_in=0x00 → out_blank=1. seg_in=0x49 → out_invalid=1. seg_in=0x7C → out_digit=6 without the macro, 0xB with SEG7_READBACK_HEX_EN.
- Assert rst while in SETTLING with out_valid=1 → all outputs 0 after the next edge. A re-presented 0x06 produces a fresh event with change_count=1.
